// File: rtl/ram_arbiter.sv
`timescale 1ns/1ps
// Registered, handshaked arbiter that shares one single-port RAM between the SD loader
// (port 0, strict priority) and CPU fetch/data (ports 1 and 2, round-robin).
module ram_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [2:0]      Anfrage,
    input  logic [2:0]      Schreiben,
    input  logic [3*AW-1:0] Adresse,
    input  logic [3*DW-1:0] DatenRein,
    output logic [2:0]      Fertig,
    output logic [DW-1:0]   DatenRaus,
    output logic            Fehler,
    output logic            Belegt,
    output logic            RAMLesenAn,
    output logic            RAMSchreibenAn,
    output logic [AW-1:0]   RAMAdresse,
    output logic [DW-1:0]   RAMDatenRein,
    input  logic [DW-1:0]   RAMDatenRaus,
    input  logic            RAMDatenBereit,
    input  logic            RAMDatenGeschrieben
);

    typedef enum logic [1:0] {LEERLAUF, ZUGRIFF, ANTWORT} state_t;

    // Last ZUGRIFF cycle index; the access is aborted when the counter sits here.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [1:0]    port_q, port_d;
    logic          ptr_q, ptr_d;       // 0: port 1 wins a tie, 1: port 2 wins
    logic [15:0]   cnt_q, cnt_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [2:0]    fertig_q, fertig_d;
    logic          fehler_q, fehler_d;
    logic          belegt_q, belegt_d;
    logic [1:0]    grant;
    logic          done;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        port_d   = port_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        fertig_d = 3'b000;
        fehler_d = fehler_q;
        belegt_d = belegt_q;

        grant = 2'd0;
        if (Anfrage[0])                     grant = 2'd0;
        else if (Anfrage[1] && Anfrage[2])  grant = ptr_q ? 2'd2 : 2'd1;
        else if (Anfrage[1])                grant = 2'd1;
        else if (Anfrage[2])                grant = 2'd2;

        // Only the completion that matches the access type counts.
        done = rd_q ? RAMDatenBereit : RAMDatenGeschrieben;

        case (state_q)
            LEERLAUF: begin
                if (|Anfrage) begin
                    port_d   = grant;
                    rd_d     = !Schreiben[grant];
                    wr_d     = Schreiben[grant];
                    addr_d   = Adresse[int'(grant)*AW +: AW];
                    wdata_d  = DatenRein[int'(grant)*DW +: DW];
                    belegt_d = 1'b1;
                    cnt_d    = 16'd0;
                    state_d  = ZUGRIFF;
                    if (grant != 2'd0) ptr_d = (grant == 2'd1);
                end
            end
            ZUGRIFF: begin
                if (done) begin
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    if (rd_q) rdata_d = RAMDatenRaus;
                    fertig_d = 3'b001 << port_q;
                    state_d  = ANTWORT;
                end else if (cnt_q == CNT_LAST) begin
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    rdata_d  = '0;
                    fehler_d = 1'b1;
                    fertig_d = 3'b001 << port_q;
                    state_d  = ANTWORT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ANTWORT: begin
                belegt_d = 1'b0;
                cnt_d    = 16'd0;
                state_d  = LEERLAUF;
            end
            default: state_d = LEERLAUF;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= LEERLAUF;
            port_q   <= 2'd0;
            ptr_q    <= 1'b0;
            cnt_q    <= 16'd0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            fertig_q <= 3'b000;
            fehler_q <= 1'b0;
            belegt_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q  <= state_d;
            port_q   <= port_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fertig_q <= fertig_d;
            fehler_q <= fehler_d;
            belegt_q <= belegt_d;
        end
    end

    assign Fertig         = fertig_q;
    assign DatenRaus      = rdata_q;
    assign Fehler         = fehler_q;
    assign Belegt         = belegt_q;
    assign RAMLesenAn     = rd_q;
    assign RAMSchreibenAn = wr_q;
    assign RAMAdresse     = addr_q;
    assign RAMDatenRein   = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
// Bench for ram_arbiter: per-port requesters push expected results into scoreboard queues,
// a RAM model answers the strobes, and a monitor checks grants, held strobes and completions.
module tb_ram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TIMEOUT = 8;

    logic            Clock = 1'b0;
    logic            Reset = 1'b1;
    logic [2:0]      Anfrage = '0;
    logic [2:0]      Schreiben = '0;
    logic [3*AW-1:0] Adresse = '0;
    logic [3*DW-1:0] DatenRein = '0;
    logic [2:0]      Fertig;
    logic [DW-1:0]   DatenRaus;
    logic            Fehler, Belegt, RAMLesenAn, RAMSchreibenAn;
    logic [AW-1:0]   RAMAdresse;
    logic [DW-1:0]   RAMDatenRein;
    logic [DW-1:0]   RAMDatenRaus = '0;
    logic            RAMDatenBereit = 1'b0;
    logic            RAMDatenGeschrieben = 1'b0;

    ram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset), .Anfrage(Anfrage), .Schreiben(Schreiben),
        .Adresse(Adresse), .DatenRein(DatenRein), .Fertig(Fertig), .DatenRaus(DatenRaus),
        .Fehler(Fehler), .Belegt(Belegt), .RAMLesenAn(RAMLesenAn), .RAMSchreibenAn(RAMSchreibenAn),
        .RAMAdresse(RAMAdresse), .RAMDatenRein(RAMDatenRein), .RAMDatenRaus(RAMDatenRaus),
        .RAMDatenBereit(RAMDatenBereit), .RAMDatenGeschrieben(RAMDatenGeschrieben)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        tmo;
    } txn_t;

    typedef enum {FREE, BUSY, ANS} phase_t;

    txn_t        exp_q[3][$];
    logic [2:0]  fertig_log[$];
    logic [31:0] ram_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    int          n_vec = 0;
    int          n_err = 0;
    bit          ram_dead = 1'b0;
    bit          force_wrong = 1'b0;
    int          force_lat = -1;
    int          ram_lat = 0;
    int          cur_port = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // RAM device model: answers after ram_lat extra cycles, optionally with stray wrong-type pulses.
    initial begin : ram_model
        bit serving;
        bit wrong;
        int cnt;
        serving = 1'b0;
        wrong = 1'b0;
        cnt = 0;
        forever begin
            @(posedge Clock);
            #2;
            RAMDatenBereit = 1'b0;
            RAMDatenGeschrieben = 1'b0;
            RAMDatenRaus = $urandom;
            if (!Reset || !(RAMLesenAn || RAMSchreibenAn)) begin
                serving = 1'b0;
                continue;
            end
            if (!serving) begin
                serving = 1'b1;
                cnt = 0;
                if (force_lat >= 0) ram_lat = force_lat;
                else if ($urandom_range(0, 9) == 0) ram_lat = TIMEOUT - 1;
                else ram_lat = $urandom_range(0, 3);
                wrong = force_wrong || ($urandom_range(0, 3) == 0);
            end else begin
                cnt++;
            end
            if (ram_dead) continue;
            if (cnt == ram_lat) begin
                if (RAMSchreibenAn) begin
                    ram_mem[RAMAdresse] = RAMDatenRein;
                    RAMDatenGeschrieben = 1'b1;
                end else begin
                    RAMDatenRaus = ram_mem.exists(RAMAdresse) ? ram_mem[RAMAdresse] : init_val(RAMAdresse);
                    RAMDatenBereit = 1'b1;
                end
            end else if (wrong && cnt < ram_lat) begin
                if (RAMSchreibenAn) RAMDatenBereit = 1'b1;
                else RAMDatenGeschrieben = 1'b1;
            end
        end
    end

    // Monitor: arbiter is free until a grant, busy until Fertig, then one answer cycle.
    initial begin : monitor
        phase_t      ph;
        int          ptr_m;
        int          g;
        int          cyc;
        logic [2:0]  req;
        logic [31:0] last_rd;
        bit          fehler_m;
        txn_t        t;
        ph = FREE; ptr_m = 1; g = 0; cyc = 0; last_rd = '0; fehler_m = 1'b0;
        t = '{wr: 1'b0, addr: '0, wdata: '0, rdata: '0, tmo: 1'b0};
        forever begin
            @(posedge Clock);
            req = Anfrage;
            #1;
            if (!Reset) begin
                ph = FREE; ptr_m = 1; last_rd = '0; fehler_m = 1'b0; cur_port = -1;
                for (int i = 0; i < 3; i++) exp_q[i].delete();
                continue;
            end
            case (ph)
                FREE: begin
                    check("fertig_idle", Fertig, 3'b000);
                    if (req != 3'b000) begin
                        if (req[0]) g = 0;
                        else if (req[1] && req[2]) g = ptr_m;
                        else g = req[1] ? 1 : 2;
                        if (g != 0) ptr_m = (g == 1) ? 2 : 1;
                        if (exp_q[g].size() == 0) begin
                            n_vec++; n_err++;
                            $display("FAIL grant_txn: port %0d granted with no request queued", g);
                        end else begin
                            t = exp_q[g][0];
                        end
                        check("grant_rd", RAMLesenAn, !t.wr);
                        check("grant_wr", RAMSchreibenAn, t.wr);
                        check("grant_addr", RAMAdresse, t.addr);
                        if (t.wr) check("grant_wdata", RAMDatenRein, t.wdata);
                        ph = BUSY; cyc = 1; cur_port = g;
                    end else begin
                        check("idle_strobes", {RAMLesenAn, RAMSchreibenAn}, 2'b00);
                    end
                end
                BUSY: begin
                    if (Fertig != 3'b000) begin
                        fertig_log.push_back(Fertig);
                        check("fertig_port", Fertig, 3'b001 << g);
                        check("done_strobes", {RAMLesenAn, RAMSchreibenAn}, 2'b00);
                        if (exp_q[g].size() != 0) t = exp_q[g].pop_front();
                        if (t.tmo) begin
                            check("timeout_cycles", cyc, TIMEOUT);
                            last_rd = '0;
                            fehler_m = 1'b1;
                        end else begin
                            check("access_cycles", cyc, ram_lat + 1);
                            if (!t.wr) last_rd = t.rdata;
                        end
                        check("daten_raus", DatenRaus, last_rd);
                        ph = ANS; cur_port = -1;
                    end else begin
                        check("held_rd", RAMLesenAn, !t.wr);
                        check("held_wr", RAMSchreibenAn, t.wr);
                        check("held_addr", RAMAdresse, t.addr);
                        if (t.wr) check("held_wdata", RAMDatenRein, t.wdata);
                        cyc++;
                    end
                end
                default: begin
                    check("ans_fertig", Fertig, 3'b000);
                    check("ans_strobes", {RAMLesenAn, RAMSchreibenAn}, 2'b00);
                    ph = FREE;
                end
            endcase
            check("belegt", Belegt, ph != FREE);
            check("fehler", Fehler, fehler_m);
        end
    end

    // One access from port p; the expected result is queued before Anfrage rises.
    task automatic do_txn(input int p, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit may_drop, input bit sync);
        txn_t t;
        int   waited;
        if (sync) @(negedge Clock);
        t.wr = wr; t.addr = addr; t.wdata = wdata; t.tmo = ram_dead;
        t.rdata = t.tmo ? 32'h0 : (ref_mem.exists(addr) ? ref_mem[addr] : init_val(addr));
        if (wr && !t.tmo) ref_mem[addr] = wdata;
        exp_q[p].push_back(t);
        Schreiben[p] = wr;
        Adresse[p*AW +: AW] = addr;
        DatenRein[p*DW +: DW] = wdata;
        Anfrage[p] = 1'b1;
        waited = 0;
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                Anfrage[p] = 1'b0;
                return;
            end
            if (Fertig[p]) break;
            if (cur_port == p) begin
                Adresse[p*AW +: AW] = $urandom;
                DatenRein[p*DW +: DW] = $urandom;
                Schreiben[p] = 1'($urandom_range(0, 1));
                if (may_drop && $urandom_range(0, 3) == 0) Anfrage[p] = 1'b0;
            end
            if (++waited > 200) begin
                n_vec++; n_err++;
                $display("FAIL fertig_wait: port %0d saw no Fertig within 200 cycles", p);
                Anfrage[p] = 1'b0;
                return;
            end
        end
        Anfrage[p] = 1'b0;
    endtask

    task automatic requester(input int p, input int n, input int min_gap, input int max_gap);
        int          gap;
        bit          wr;
        logic [31:0] a;
        @(negedge Clock);
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(min_gap, max_gap);
            wr  = 1'($urandom_range(0, 1));
            a   = 32'h1000 * (p + 1) + 32'($urandom_range(0, 7)) * 4;
            repeat (gap) @(negedge Clock);
            do_txn(p, wr, a, $urandom, max_gap > 0, 1'b0);
        end
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int w;
        #2 Reset = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_fertig", Fertig, 3'b000);
        check("rst_strobes", {RAMLesenAn, RAMSchreibenAn}, 2'b00);
        check("rst_belegt_fehler", {Belegt, Fehler}, 2'b00);
        check("rst_datenraus", DatenRaus, 32'h0);
        @(negedge Clock) Reset = 1'b1;

        // Single port-1 read of a known word.
        ram_mem[32'h10] = 32'hDEAD_BEEF;
        ref_mem[32'h10] = 32'hDEAD_BEEF;
        force_lat = 1;
        fertig_log.delete();
        do_txn(1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
        check("t1_datenraus", DatenRaus, 32'hDEAD_BEEF);
        check("t1_fertig_once", fertig_log.size(), 1);

        // Read with stray write-complete pulses before the real data.
        force_lat = 3; force_wrong = 1'b1;
        do_txn(1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b1);
        check("t6_datenraus", DatenRaus, init_val(32'h14));
        force_wrong = 1'b0;

        // Port 2 write in flight while ports 0 and 1 arrive: 2, then 0, then 1.
        fertig_log.delete();
        fork
            do_txn(2, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b1);
            begin
                w = 0;
                while (cur_port != 2 && w < 50) begin
                    @(negedge Clock);
                    w++;
                end
                fork
                    do_txn(0, 1'b1, 32'h24, 32'hCAFE_0000, 1'b0, 1'b0);
                    do_txn(1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
                join
            end
        join
        check("t3_count", fertig_log.size(), 3);
        if (fertig_log.size() == 3) begin
            check("t3_first", fertig_log[0], 3'b100);
            check("t3_second", fertig_log[1], 3'b001);
            check("t3_third", fertig_log[2], 3'b010);
        end
        check("t3_ram_word", ram_mem[32'h20], 32'h1234_5678);

        // Random traffic from all three ports.
        force_lat = -1;
        fork
            requester(0, 12, 4, 12);
            requester(1, 30, 0, 3);
            requester(2, 30, 0, 3);
        join

        // RAM stops answering: every access times out and Fehler latches.
        ram_dead = 1'b1;
        do_txn(2, 1'b1, 32'h3000, 32'hAAAA_5555, 1'b0, 1'b1);
        check("t4_datenraus", DatenRaus, 32'h0);
        do_txn(1, 1'b0, 32'h2004, 32'h0, 1'b0, 1'b1);
        check("t4_fehler", Fehler, 1'b1);
        ram_dead = 1'b0;
        fork
            requester(0, 4, 2, 6);
            requester(1, 10, 0, 3);
            requester(2, 10, 0, 3);
        join
        check("t4_fehler_sticky", Fehler, 1'b1);

        // Asynchronous reset in the middle of an access.
        ram_dead = 1'b1;
        fork
            do_txn(1, 1'b1, 32'h2008, 32'h0BAD_F00D, 1'b0, 1'b1);
            begin
                w = 0;
                while (!RAMSchreibenAn && w < 50) begin
                    @(negedge Clock);
                    w++;
                end
                repeat (2) @(negedge Clock);
                #3 Reset = 1'b0;
                #1;
                check("t5_strobes", {RAMLesenAn, RAMSchreibenAn}, 2'b00);
                check("t5_belegt", Belegt, 1'b0);
                check("t5_fertig", Fertig, 3'b000);
                check("t5_fehler", Fehler, 1'b0);
                repeat (2) @(negedge Clock);
                Reset = 1'b1;
            end
        join
        ram_dead = 1'b0;
        force_lat = 0;
        fertig_log.delete();
        fork
            do_txn(1, 1'b0, 32'h2000, 32'h0, 1'b0, 1'b1);
            do_txn(2, 1'b0, 32'h3000, 32'h0, 1'b0, 1'b1);
        join
        check("t5_count", fertig_log.size(), 2);
        if (fertig_log.size() == 2) begin
            check("t5_first_port1", fertig_log[0], 3'b010);
            check("t5_then_port2", fertig_log[1], 3'b100);
        end

        // Ports 1 and 2 requesting back to back alternate strictly.
        fertig_log.delete();
        fork
            requester(1, 6, 0, 0);
            requester(2, 6, 0, 0);
        join
        check("t2_count", fertig_log.size(), 12);
        for (int i = 1; i < fertig_log.size(); i++)
            check("t2_alternate", fertig_log[i], (fertig_log[i-1] == 3'b010) ? 3'b100 : 3'b010);

        repeat (4) @(negedge Clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
